tile_row_fetcher: RTL and testbench
===================================

# tile_row_fetcher

Streams one scanline of 1-bpp tile pixels for the VGA tile renderer. Per line, it reads tile indices from the tile map RAM and tile row bitmaps from the tile ROM. Both memories have one-cycle synchronous read latency. It serialises each bitmap MSB-first onto a valid/ready pixel stream that feeds the line buffer. It is the read-side client of the tile ROM port (`addr` out, `rdata` in).

## Interface
- `ADDR_WIDTH`, 7: tile ROM address width; `{tile_idx, row}`.
- `DATA_WIDTH`, 8: pixels per tile row; ROM data width.
- `ROW_BITS`, 3: row-within-tile bits; tile index width `TW = ADDR_WIDTH-ROW_BITS`.
- `MAP_ADDR_WIDTH`, 7: tile map address width.
- `TILES_PER_LINE`, 80: tiles fetched per line; must be ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `line_start`  in  1  one-cycle request; accepted only when `busy`=0.
- `line_row`  in  `ROW_BITS`  row within tile, captured on accept.
- `line_base`  in  `MAP_ADDR_WIDTH`  map address of the line's first tile, captured on accept.
- `busy`  out  1  high when state ≠ IDLE.
- `line_done`  out  1  one-cycle pulse after the last pixel handshake.
- `map_addr`  out  `MAP_ADDR_WIDTH`  tile map read address.
- `map_rdata`  in  `TW`  tile index, valid the cycle after `map_addr`.
- `rom_addr`  out  `ADDR_WIDTH`  tile ROM read address.
- `rom_rdata`  in  `DATA_WIDTH`  bitmap row, valid the cycle after `rom_addr`.
- `pix`  out  1  pixel value.
- `pix_valid`  out  1  `pix` is valid.
- `pix_ready`  in  1  downstream accepts the pixel.

## Operation
**Registers**
- `row_q`, `base_q`, `fetched` (counter, 0..`TILES_PER_LINE`), `tile_q`.
- `hold` plus `hold_full`: one-deep bitmap buffer.
- `shreg` plus `pcnt`: pixels remaining, 0..`DATA_WIDTH`.

**Fetch FSM**
- IDLE: on `line_start`, capture `line_row`→`row_q` and `line_base`→`base_q`, clear `fetched`, go to MAP.
- MAP: `map_addr = base_q + fetched`, taken modulo 2^`MAP_ADDR_WIDTH` (wraps). Go to ROM.
- ROM: `rom_addr = {map_rdata, row_q}`; `tile_q <= map_rdata`. Go to CAP.
- CAP: `rom_addr = {tile_q, row_q}`. Held stable, so `rom_rdata` stays valid while waiting.
  - If `hold_full`=0, or `hold` is being moved to `shreg` this cycle: write `hold <= rom_rdata` and increment `fetched`.
  - Then go to DRAIN if the new `fetched` = `TILES_PER_LINE`, else MAP.
  - Otherwise stay in CAP.
- DRAIN: when `hold_full`=0 and `pcnt`=0, assert `line_done` (combinational, this cycle only) and go to IDLE.
- `map_addr`/`rom_addr` outside the states above: `base_q+fetched` and `{tile_q,row_q}`.

**Shifter**
- `pix = shreg[DATA_WIDTH-1]`, `pix_valid = (pcnt≠0)`.
- Handshake (`pix_valid & pix_ready`): shift `shreg` left by 1, decrement `pcnt`.
- Load `hold`→`shreg`, set `pcnt=DATA_WIDTH`, clear `hold_full` when `hold_full`=1 and either:
  - `pcnt`=0, or
  - `pcnt`=1 with a handshake this cycle (no bubble).
- A simultaneous CAP write and hold→shreg load leaves `hold_full`=1 with the new data.

**Other rules**
- `line_start` while `busy`=1 is ignored.
- `pix_ready` low stalls the shifter only; fetch continues until `hold` is full.
- `rst_n` low at any time, including mid-line: all registers clear and state goes to IDLE immediately. No resume; a new `line_start` is required.

## Timing
- Reset values: `busy`=0, `line_done`=0, `pix`=0, `pix_valid`=0, `map_addr`=0, `rom_addr`=0, `hold_full`=0, `pcnt`=0.
- Sequence with `line_start` sampled high at cycle 0: MAP in cycle 1, ROM in 2, CAP in 3, `hold` loaded at the end of 3, `shreg` loaded at the end of 4, first `pix_valid` in cycle 5.
- Fetch takes 3 cycles per tile against 8 pixels per tile. With `pix_ready`=1 throughout, `pix_valid` stays high continuously from cycle 5 for `TILES_PER_LINE*DATA_WIDTH` cycles.
- `line_done` is high in the cycle after the final handshake. `busy` falls the next cycle. The earliest accepted new `line_start` is that cycle.

## Test plan
- **Reset and first fetch:** reset, then `line_start` with `line_base`=0x10 and `line_row`=3.
  - `map_addr`=0x10 in cycle 1.
  - map returns 0x5, so `rom_addr`=0x2B in cycle 2.
  - First `pix_valid` in cycle 5.
- **Bit order:** `TILES_PER_LINE`=2, ROM rows 0xA5 then 0x3C, `pix_ready`=1.
  - `pix` = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on 16 consecutive cycles.
  - `line_done` on the 17th cycle.
- **Backpressure:** toggle `pix_ready` every other cycle.
  - Identical 16-bit sequence, no loss or duplication.
  - FSM stalls in CAP with `rom_addr` stable.
- **Map wrap:** `line_base`=0x7F, `TILES_PER_LINE`=2 → `map_addr` sequence 0x7F, 0x00.
- **Busy line start:** pulse `line_start` with a different base while `busy`=1 → ignored; the line completes with the original data.
- **Reset mid-line:** assert `rst_n`=0 mid-line, after 7 pixels.
  - All outputs go to reset values asynchronously.
  - After release, a new `line_start` produces a correct full line.

Source files
------------

// File: rtl/tile_row_fetcher.sv
// Fetches one scanline of 1-bpp tiles (map RAM -> tile ROM) and serialises
// each bitmap row MSB-first onto a valid/ready pixel stream.
module tile_row_fetcher #(
   parameter int ADDR_WIDTH     = 7,
   parameter int DATA_WIDTH     = 8,
   parameter int ROW_BITS       = 3,
   parameter int MAP_ADDR_WIDTH = 7,
   parameter int TILES_PER_LINE = 80
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             line_start,
   input  logic [ROW_BITS-1:0]              line_row,
   input  logic [MAP_ADDR_WIDTH-1:0]        line_base,
   output logic                             busy,
   output logic                             line_done,
   output logic [MAP_ADDR_WIDTH-1:0]        map_addr,
   input  logic [ADDR_WIDTH-ROW_BITS-1:0]   map_rdata,
   output logic [ADDR_WIDTH-1:0]            rom_addr,
   input  logic [DATA_WIDTH-1:0]            rom_rdata,
   output logic                             pix,
   output logic                             pix_valid,
   input  logic                             pix_ready
);

   localparam int TW = ADDR_WIDTH - ROW_BITS;
   localparam int FW = $clog2(TILES_PER_LINE + 1);
   localparam int PW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {IDLE, MAP, ROM, CAP, DRAIN} state_t;

   state_t                    state_reg, state_next;
   logic [ROW_BITS-1:0]       row_reg;
   logic [MAP_ADDR_WIDTH-1:0] base_reg;
   logic [FW-1:0]             fetched_reg;
   logic [TW-1:0]             tile_reg;
   logic [DATA_WIDTH-1:0]     hold_reg;
   logic                      hold_full_reg;
   logic [DATA_WIDTH-1:0]     shreg_reg;
   logic [PW-1:0]             pcnt_reg;

   logic [DATA_WIDTH-1:0]     shreg_shift;
   logic [FW-1:0]             fetched_inc;
   logic                      handshake;
   logic                      load;
   logic                      cap_write;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
         if (gi == 0) begin : g_lsb
            assign shreg_shift[gi] = 1'b0;
         end else begin : g_upper
            assign shreg_shift[gi] = shreg_reg[gi-1];
         end
      end
   endgenerate

   assign pix         = shreg_reg[DATA_WIDTH-1];
   assign pix_valid   = (pcnt_reg != '0);
   assign handshake   = pix_valid & pix_ready;
   assign busy        = (state_reg != IDLE);
   assign fetched_inc = fetched_reg + FW'(1);
   // Refill on the last pixel's handshake too, so tiles stream without a bubble.
   assign load = hold_full_reg &
                 ((pcnt_reg == '0) | ((pcnt_reg == PW'(1)) & pix_ready));

   always_comb begin
      state_next = state_reg;
      cap_write  = 1'b0;
      line_done  = 1'b0;
      map_addr   = base_reg + MAP_ADDR_WIDTH'(fetched_reg);
      rom_addr   = {tile_reg, row_reg};
      case (state_reg)
         IDLE: begin
            if (line_start) state_next = MAP;
         end
         MAP: begin
            state_next = ROM;
         end
         ROM: begin
            rom_addr   = {map_rdata, row_reg};
            state_next = CAP;
         end
         CAP: begin
            // rom_addr is held, so rom_rdata stays valid while hold is busy.
            if (!hold_full_reg || load) begin
               cap_write  = 1'b1;
               state_next = (fetched_inc == FW'(TILES_PER_LINE)) ? DRAIN : MAP;
            end
         end
         DRAIN: begin
            if (!hold_full_reg && (pcnt_reg == '0)) begin
               line_done  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         row_reg       <= '0;
         base_reg      <= '0;
         fetched_reg   <= '0;
         tile_reg      <= '0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         shreg_reg     <= '0;
         pcnt_reg      <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && line_start) begin
            row_reg     <= line_row;
            base_reg    <= line_base;
            fetched_reg <= '0;
         end
         if (state_reg == ROM) tile_reg <= map_rdata;
         if (cap_write) begin
            hold_reg    <= rom_rdata;
            fetched_reg <= fetched_inc;
         end
         // A same-cycle capture wins: hold stays full with the new row.
         if (cap_write)  hold_full_reg <= 1'b1;
         else if (load)  hold_full_reg <= 1'b0;
         if (load) begin
            shreg_reg <= hold_reg;
            pcnt_reg  <= PW'(DATA_WIDTH);
         end else if (handshake) begin
            shreg_reg <= shreg_shift;
            pcnt_reg  <= pcnt_reg - PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_tile_row_fetcher.sv
// Scoreboard bench for tile_row_fetcher: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every pixel handshake.
module tb_tile_row_fetcher;

   localparam int AW  = 7;
   localparam int DW  = 8;
   localparam int RB  = 3;
   localparam int MAW = 7;
   localparam int TPL = 3;
   localparam int TW  = AW - RB;

   logic           clk;
   logic           rst_n;
   logic           line_start;
   logic [RB-1:0]  line_row;
   logic [MAW-1:0] line_base;
   logic           busy;
   logic           line_done;
   logic [MAW-1:0] map_addr;
   logic [TW-1:0]  map_rdata;
   logic [AW-1:0]  rom_addr;
   logic [DW-1:0]  rom_rdata;
   logic           pix;
   logic           pix_valid;
   logic           pix_ready;

   tile_row_fetcher #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW_BITS(RB),
      .MAP_ADDR_WIDTH(MAW), .TILES_PER_LINE(TPL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_row(line_row),
      .line_base(line_base), .busy(busy), .line_done(line_done),
      .map_addr(map_addr), .map_rdata(map_rdata), .rom_addr(rom_addr),
      .rom_rdata(rom_rdata), .pix(pix), .pix_valid(pix_valid),
      .pix_ready(pix_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [TW-1:0] map_mem [0:127];
   logic [DW-1:0] rom_mem [0:127];

   always @(posedge clk) begin
      map_rdata <= map_mem[map_addr];
      rom_rdata <= rom_mem[rom_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors   = 0;
   int checks   = 0;
   int hs_cnt   = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int t0       = 0;
   int rdy_mode = 0;
   bit exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      bit e;
      if (line_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (pix_valid && pix_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix_extra: got pixel %0b expected no pixel", pix);
         end else begin
            e = exp_q.pop_front();
            chk("pix", {31'b0, pix}, {31'b0, e});
         end
      end
   end

   initial begin
      pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            default: pix_ready = 1'b0;
         endcase
      end
   end

   task automatic push_line(input logic [MAW-1:0] base, input logic [RB-1:0] row);
      logic [MAW-1:0] a;
      logic [TW-1:0]  idx;
      logic [DW-1:0]  d;
      for (int k = 0; k < TPL; k++) begin
         a   = base + MAW'(k);
         idx = map_mem[a];
         d   = rom_mem[{idx, row}];
         for (int b = DW - 1; b >= 0; b--) exp_q.push_back(d[b]);
      end
   endtask

   task automatic start_line(input logic [MAW-1:0] base, input logic [RB-1:0] row);
      push_line(base, row);
      @(posedge clk);
      #1;
      line_base  = base;
      line_row   = row;
      line_start = 1'b1;
      t0         = cyc;
      @(posedge clk);
      #1;
      line_start = 1'b0;
   endtask

   task automatic at_cycle(input int n);
      do @(negedge clk); while (cyc - t0 < n);
   endtask

   task automatic wait_done(input string name, input int exp_rel);
      int n0;
      int k;
      n0 = done_cnt;
      k  = 0;
      while (done_cnt == n0 && k < 1000) begin
         @(posedge clk);
         k++;
      end
      if (done_cnt == n0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no line_done expected line_done within 1000 cycles", name);
      end else begin
         if (exp_rel >= 0) chk({name, "_done_cycle"}, done_cyc - t0, exp_rel);
         @(negedge clk);
         chk({name, "_busy_after"}, {31'b0, busy}, 32'd0);
         chk({name, "_done_width"}, {31'b0, line_done}, 32'd0);
         chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
         $display("line %s: done at cycle %0d after start, pixels so far %0d", name, done_cyc - t0, hs_cnt);
      end
   endtask

   initial begin
      int h0;
      int k;
      rst_n      = 1'b0;
      line_start = 1'b0;
      line_base  = '0;
      line_row   = '0;
      for (int i = 0; i < 128; i++) begin
         map_mem[i] = '0;
         rom_mem[i] = '0;
      end
      map_mem[7'h10] = 4'd5;  map_mem[7'h11] = 4'd6;  map_mem[7'h12] = 4'd7;
      rom_mem[43] = 8'hA5;    rom_mem[51] = 8'h3C;    rom_mem[59] = 8'hF0;
      map_mem[7'h7F] = 4'd1;  map_mem[7'h00] = 4'd2;  map_mem[7'h01] = 4'd3;
      rom_mem[13] = 8'h81;    rom_mem[21] = 8'h7E;    rom_mem[29] = 8'hC3;
      map_mem[7'h20] = 4'd9;  map_mem[7'h21] = 4'd10; map_mem[7'h22] = 4'd11;
      rom_mem[72] = 8'h96;    rom_mem[80] = 8'h55;    rom_mem[88] = 8'hE1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_line_done", {31'b0, line_done}, 32'd0);
      chk("rst_pix", {31'b0, pix}, 32'd0);
      chk("rst_pix_valid", {31'b0, pix_valid}, 32'd0);
      chk("rst_map_addr", {25'b0, map_addr}, 32'd0);
      chk("rst_rom_addr", {25'b0, rom_addr}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // First fetch timing and bit order (A5, 3C, F0)
      rdy_mode = 0;
      start_line(7'h10, 3'd3);
      at_cycle(1);
      chk("first_map_addr", {25'b0, map_addr}, 32'h10);
      chk("first_busy", {31'b0, busy}, 32'd1);
      at_cycle(2);
      chk("first_rom_addr", {25'b0, rom_addr}, 32'h2B);
      at_cycle(3);
      chk("first_valid_c3", {31'b0, pix_valid}, 32'd0);
      at_cycle(4);
      chk("first_valid_c4", {31'b0, pix_valid}, 32'd0);
      at_cycle(5);
      chk("first_valid_c5", {31'b0, pix_valid}, 32'd1);
      wait_done("first", 5 + TPL * DW);

      // Map address wrap
      start_line(7'h7F, 3'd5);
      at_cycle(1);
      chk("wrap_map_addr0", {25'b0, map_addr}, 32'h7F);
      at_cycle(4);
      chk("wrap_map_addr1", {25'b0, map_addr}, 32'h00);
      at_cycle(7);
      chk("wrap_map_addr2", {25'b0, map_addr}, 32'h01);
      wait_done("wrap", 5 + TPL * DW);

      // Backpressure: stall in CAP with the third tile's ROM address held
      rdy_mode = 2;
      start_line(7'h20, 3'd0);
      for (int n = 9; n <= 15; n++) begin
         at_cycle(n);
         chk("stall_rom_addr", {25'b0, rom_addr}, 32'h58);
         chk("stall_busy", {31'b0, busy}, 32'd1);
      end
      rdy_mode = 1;
      wait_done("backpressure", -1);

      // line_start while busy is ignored
      rdy_mode = 0;
      start_line(7'h10, 3'd3);
      at_cycle(8);
      @(posedge clk);
      #1;
      line_base  = 7'h7F;
      line_row   = 3'd5;
      line_start = 1'b1;
      @(posedge clk);
      #1;
      line_start = 1'b0;
      wait_done("busy_ignore", 5 + TPL * DW);

      // Asynchronous reset after 7 pixels, then a fresh line
      start_line(7'h20, 3'd0);
      h0 = hs_cnt - 0;
      k  = 0;
      while (hs_cnt < h0 + 7 && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk("midreset_pixels", hs_cnt - h0, 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", {31'b0, busy}, 32'd0);
      chk("midreset_pix_valid", {31'b0, pix_valid}, 32'd0);
      chk("midreset_pix", {31'b0, pix}, 32'd0);
      chk("midreset_line_done", {31'b0, line_done}, 32'd0);
      chk("midreset_map_addr", {25'b0, map_addr}, 32'd0);
      chk("midreset_rom_addr", {25'b0, rom_addr}, 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      start_line(7'h7F, 3'd5);
      wait_done("after_reset", 5 + TPL * DW);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000 time units");
      $fatal(1, "watchdog");
   end

endmodule
